// File: rtl/wb_uart_master.sv
// Byte-stream command decoder driving a Wishbone classic master; replies through a UART byte interface.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_uart_master #(
  parameter int timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [2:0] {IDLE, ADR, DAT, BUS, RSP} state_t;

  state_t      state;
  logic        is_write;
  logic        status_ok;
  logic        status_sent;
  logic [1:0]  cnt;
  logic [31:0] rsp_data;
  logic        timed_out;
  logic        bus_done;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_cnt;

  // Fires on the last permitted BUS cycle so cyc/stb drop on the following one.
  assign timed_out = (tmo_cnt == TW'(timeout_cycles - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == BUS && !bus_done) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles > 0);
  assign timed_out = 1'b0;
`endif

  assign bus_done = wb_ack_i || wb_err_i || timed_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      status_ok   <= 1'b0;
      status_sent <= 1'b0;
      cnt         <= 2'd0;
      rsp_data    <= 32'd0;
      tx_data     <= 8'd0;
      tx_wr       <= 1'b0;
      wb_adr_o    <= 32'd0;
      wb_dat_o    <= 32'd0;
      wb_sel_o    <= 4'h0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_avail && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            is_write <= (rx_data == 8'h01);
            cnt      <= 2'd0;
            state    <= ADR;
          end
        end

        ADR: begin
          if (rx_avail) begin
            wb_adr_o <= {wb_adr_o[23:0], rx_data};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (is_write) begin
                state <= DAT;
              end else begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= 1'b0;
                state    <= BUS;
              end
            end
          end
        end

        DAT: begin
          if (rx_avail) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_we_o  <= 1'b1;
              state    <= BUS;
            end
          end
        end

        BUS: begin
          if (bus_done) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= 4'h0;
            // Simultaneous ack and err is reported as an error.
            status_ok   <= wb_ack_i && !wb_err_i;
            status_sent <= 1'b0;
            cnt         <= 2'd0;
            if (wb_ack_i && !wb_err_i && !is_write) begin
              rsp_data <= wb_dat_i;
            end
            state <= RSP;
          end
        end

        RSP: begin
          // tx_wr still high here means a byte was loaded last cycle; skip one.
          if (!tx_busy && !tx_wr) begin
            tx_wr <= 1'b1;
            if (!status_sent) begin
              tx_data     <= status_ok ? 8'hAA : 8'hEE;
              status_sent <= 1'b1;
              if (!status_ok || is_write) begin
                state <= IDLE;
              end
            end else begin
              tx_data  <= rsp_data[31:24];
              rsp_data <= {rsp_data[23:0], 8'h00};
              cnt      <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                state <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_uart_master.md
WB_UART_MASTER -- requirements
Module: wb_uart_master

Interface
REQ-001 SHALL have parameter: timeout_cycles, default 1024, bus-cycle watchdog limit in clk cycles (used only with WB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rx_data  input  8  received byte from UART core.
REQ-005 SHALL have port: rx_avail  input  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port: tx_data  output  8  byte to transmit.
REQ-007 SHALL have port: tx_wr  output  1  one-cycle strobe, load tx_data into UART core.
REQ-008 SHALL have port: tx_busy  input  1  UART transmitter busy.
REQ-009 SHALL have ports: wb_adr_o output 32, wb_dat_o output 32, wb_dat_i input 32, wb_sel_o output 4, wb_we_o output 1, wb_cyc_o output 1, wb_stb_o output 1, wb_ack_i input 1, wb_err_i input 1; Wishbone classic master.

Function
REQ-010 SHALL implement states IDLE, ADR, DAT, BUS, RSP.
REQ-011 IDLE: on rx_avail with rx_data 0x01 (write) or 0x02 (read), latch command, go ADR; any other byte SHALL be discarded, stay IDLE.
REQ-012 ADR: SHALL shift 4 bytes MSB-first into wb_adr_o; after 4th byte go DAT (write) or BUS (read).
REQ-013 DAT: SHALL shift 4 bytes MSB-first into wb_dat_o; after 4th byte go BUS.
REQ-014 BUS: wb_cyc_o=wb_stb_o=1 from the cycle after the last command byte, wb_sel_o=4'hF, wb_we_o=1 for write only; held until wb_ack_i or wb_err_i sampled high.
REQ-015 cyc/stb SHALL deassert in the cycle after ack/err is sampled; ack and err together SHALL count as err.
REQ-016 On ack of a read, wb_dat_i SHALL be captured in the same edge into a response register.
REQ-017 RSP: SHALL send status byte 0xAA (ack) or 0xEE (err/timeout); for successful read, followed by 4 captured bytes MSB-first; then IDLE.
REQ-018 tx_wr SHALL pulse only when tx_busy=0 and SHALL NOT assert in the cycle directly after a previous tx_wr pulse.
REQ-019 rx_avail during BUS or RSP SHALL be ignored, no buffering.
REQ-020 Address counter and byte counters SHALL be 2 bits; no partial-frame timeout; a frame stays pending indefinitely.
REQ-021 wb_adr_o/wb_dat_o SHALL hold last values after a cycle.

Reset
REQ-022 reset SHALL immediately force state IDLE, counters 0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, tx_wr=0, tx_data=0.
REQ-023 reset during BUS SHALL drop cyc/stb asynchronously and discard the pending response.

Configuration
REQ-024 Macro WB_MASTER_TIMEOUT_EN: when defined, BUS SHALL count clk cycles; if no ack/err after timeout_cycles cycles, cyc/stb deassert next cycle and status 0xEE is sent.
REQ-025 Without WB_MASTER_TIMEOUT_EN, no counter SHALL exist; BUS waits indefinitely.

Verification
REQ-026 Bytes 01 00 00 10 00 DE AD BE EF, slave acks after 2 cycles -> one bus write adr 0x00001000 dat 0xDEADBEEF sel F we 1; tx 0xAA.
REQ-027 Bytes 02 70 00 00 04, slave returns 0x12345678 with ack -> read with we 0; tx AA 12 34 56 78 in order.
REQ-028 Bytes 55 02 00 00 00 00 -> 0x55 dropped; read of adr 0x00000000 performed.
REQ-029 Read with slave asserting wb_err_i -> tx single 0xEE, no data bytes.
REQ-030 tx_busy held high 100 cycles during RSP -> no tx_wr until release, then bytes unchanged.
REQ-031 WB_MASTER_TIMEOUT_EN, timeout_cycles=16, slave never acks -> cyc drops after 16 cycles, tx 0xEE; reset asserted mid-BUS -> cyc=0 same cycle, no tx.
